// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and helpers for the data-memory arbiter:
//   state_t   - arbiter FSM states (IDLE, ACCESS, RESP)
//   M0 / M1   - requester IDs (M0 = CPU load/store unit, M1 = loader/debug)
//   addr_err  - flags a word access that is misaligned or out of range
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Word access is legal only when word aligned and the last byte of the
    // word still lies inside the memory. Arguments are widened to 64 bits
    // so callers with any address width up to 64 can use it.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input logic [63:0] mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > (mem_bytes - 64'd4));
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Holds the tie-break pointer and produces a
// one-hot grant for the current cycle.
// Ports:
//   clk, rstn   clock and asynchronous active-low reset
//   i_req       request vector, bit 0 = M0, bit 1 = M1
//   i_advance   arbitration window; no grant is produced outside it
//   o_grant     one-hot grant (combinational)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Requester that wins when both ask: always the one not granted last.
    logic r_pref;

    always_comb begin
        o_grant = 2'b00;
        if (i_advance) begin
            if (i_req == 2'b11) begin
                o_grant = (r_pref == M1) ? 2'b10 : 2'b01;
            end else begin
                o_grant = i_req;
            end
        end
    end

    // Granting M0 hands the next tie to M1 and vice versa.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pref <= M0;
        end else if (o_grant != 2'b00) begin
            r_pref <= o_grant[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port, byte-addressed data memory between M0 (CPU LSU)
// and M1 (loader/debug port) with round-robin arbitration.
//
// Handshake (both requesters): a requester raises i_reqX with a stable
// command and holds it until it sees o_gntX (one-cycle pulse, registered:
// one cycle after the request was arbitrated). It may change or drop the
// command from the cycle after o_gntX. Exactly one o_rvalidX pulse follows
// the grant one cycle later, for reads and writes alike; o_rData and o_err
// are meaningful only with it. Dropping i_reqX before o_gntX withdraws it.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   i_req0/1, i_we0/1            request and write-enable per requester
//   i_addr0/1, i_wData0/1        byte address and write data per requester
//   o_gnt0/1                     command accepted (1-cycle pulse)
//   o_rvalid0/1                  response (1-cycle pulse)
//   o_rData, o_err               response data / error qualifier
//   o_busy                       high whenever the FSM is not IDLE
//   o_DMem_we/addr/wData         memory command, active only in ACCESS
//   i_DMem_rData                 combinational memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wData0,
    input  logic [DW-1:0] i_wData1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_rvalid0,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rData,
    output logic          o_err,
    output logic          o_busy,
    output logic          o_DMem_we,
    output logic [AW-1:0] o_DMem_addr,
    output logic [DW-1:0] o_DMem_wData,
    input  logic [DW-1:0] i_DMem_rData
);

    state_t        r_state;
    state_t        w_next_state;

    // Latched command of the transaction currently in ACCESS/RESP.
    logic          r_id;
    logic          r_we;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;

    logic          w_arb_en;
    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic          w_win_id;
    logic          w_win_we;
    logic          w_win_err;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

    // Arbitration only happens when no command is in ACCESS; RESP overlaps
    // with the next arbitration to reach one access every two cycles.
    assign w_arb_en = (r_state == IDLE) || (r_state == RESP);
    assign w_req    = {i_req1, i_req0} & {2{w_arb_en}};

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (w_req),
        .i_advance (w_arb_en),
        .o_grant   (w_grant)
    );

    // Grant is one-hot, so bit 1 alone identifies the winner.
    assign w_win_id    = w_grant[1];
    assign w_win_we    = w_win_id ? i_we1    : i_we0;
    assign w_win_addr  = w_win_id ? i_addr1  : i_addr0;
    assign w_win_wdata = w_win_id ? i_wData1 : i_wData0;
    assign w_win_err   = addr_err(64'(w_win_addr), 64'(MEM_BYTES));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, RESP: w_next_state = (w_grant != 2'b00) ? ACCESS : IDLE;
            ACCESS:     w_next_state = RESP;
            default:    w_next_state = IDLE;
        endcase
    end

    // ---------------- command latch and response register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_id    <= M0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant != 2'b00) begin
                r_id    <= w_win_id;
                r_we    <= w_win_we;
                r_err   <= w_win_err;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
            end
            // Writes and rejected accesses return zero data.
            if (r_state == ACCESS) begin
                r_rdata <= (r_we || r_err) ? '0 : i_DMem_rData;
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_gnt0       = (r_state == ACCESS) && (r_id == M0);
    assign o_gnt1       = (r_state == ACCESS) && (r_id == M1);
    assign o_rvalid0    = (r_state == RESP)   && (r_id == M0);
    assign o_rvalid1    = (r_state == RESP)   && (r_id == M1);
    assign o_rData      = (r_state == RESP)   ? r_rdata : '0;
    assign o_err        = (r_state == RESP)   && r_err;
    assign o_busy       = (r_state != IDLE);
    assign o_DMem_we    = (r_state == ACCESS) && r_we && !r_err;
    assign o_DMem_addr  = (r_state == ACCESS) ? r_addr  : '0;
    assign o_DMem_wData = (r_state == ACCESS) ? r_wdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 256;
    localparam int AW        = 32;
    localparam int DW        = 32;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic          i_req0, i_req1, i_we0, i_we1;
    logic [AW-1:0] i_addr0, i_addr1;
    logic [DW-1:0] i_wData0, i_wData1;
    logic          o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_err, o_busy, o_DMem_we;
    logic [DW-1:0] o_rData, o_DMem_wData, i_DMem_rData;
    logic [AW-1:0] o_DMem_addr;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_req0       (i_req0),
        .i_req1       (i_req1),
        .i_we0        (i_we0),
        .i_we1        (i_we1),
        .i_addr0      (i_addr0),
        .i_addr1      (i_addr1),
        .i_wData0     (i_wData0),
        .i_wData1     (i_wData1),
        .o_gnt0       (o_gnt0),
        .o_gnt1       (o_gnt1),
        .o_rvalid0    (o_rvalid0),
        .o_rvalid1    (o_rvalid1),
        .o_rData      (o_rData),
        .o_err        (o_err),
        .o_busy       (o_busy),
        .o_DMem_we    (o_DMem_we),
        .o_DMem_addr  (o_DMem_addr),
        .o_DMem_wData (o_DMem_wData),
        .i_DMem_rData (i_DMem_rData)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory attached to the DUT ----------------
    logic [7:0] mem [0:255];
    logic [7:0] ea0, ea1, ea2, ea3;
    assign ea0 = o_DMem_addr[7:0];
    assign ea1 = ea0 + 8'd1;
    assign ea2 = ea0 + 8'd2;
    assign ea3 = ea0 + 8'd3;
    assign i_DMem_rData = {mem[ea3], mem[ea2], mem[ea1], mem[ea0]};

    always @(posedge clk) begin
        if (o_DMem_we) begin
            mem[ea0] <= o_DMem_wData[7:0];
            mem[ea1] <= o_DMem_wData[15:8];
            mem[ea2] <= o_DMem_wData[23:16];
            mem[ea3] <= o_DMem_wData[31:24];
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic        id;
        logic        we;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
    } txn_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } cmd_t;

    logic [7:0]  ref_mem [0:255];
    txn_t        acc;      // transaction expected to show gnt/memory access this cycle
    txn_t        rsp;      // transaction expected to show rvalid this cycle
    logic        last_id;  // requester granted most recently
    cmd_t        q0[$], q1[$];
    int          m_st  [2];  // 0 free, 1 pending, 2 chosen, 3 granted
    logic        m_req [2];
    logic        m_we  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd  [2];
    logic        rnd_mode = 1'b0;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    int          gnt_id_q[$], gnt_cyc_q[$], rv0_cyc_q[$];
    logic [31:0] rd0_q[$], rd1_q[$];
    logic        err1_q[$];
    logic        we_seen;

    function automatic logic exp_err(input logic [31:0] a);
        return ((a % 4) != 0) || (a > 32'(MEM_BYTES - 4));
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int b;
        b = int'(a[7:0]);
        return {ref_mem[(b + 3) % 256], ref_mem[(b + 2) % 256], ref_mem[(b + 1) % 256], ref_mem[b]};
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
        int b;
        b = int'(a[7:0]);
        ref_mem[b]             = d[7:0];
        ref_mem[(b + 1) % 256] = d[15:8];
        ref_mem[(b + 2) % 256] = d[23:16];
        ref_mem[(b + 3) % 256] = d[31:24];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $error("FAIL timeout_%s observed=not_idle expected=idle", tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt0"},   32'(o_gnt0),    32'd0);
        chk({tag, "_gnt1"},   32'(o_gnt1),    32'd0);
        chk({tag, "_rv0"},    32'(o_rvalid0), 32'd0);
        chk({tag, "_rv1"},    32'(o_rvalid1), 32'd0);
        chk({tag, "_rdata"},  o_rData,        32'd0);
        chk({tag, "_err"},    32'(o_err),     32'd0);
        chk({tag, "_busy"},   32'(o_busy),    32'd0);
        chk({tag, "_mwe"},    32'(o_DMem_we), 32'd0);
        chk({tag, "_maddr"},  o_DMem_addr,    32'd0);
        chk({tag, "_mwdata"}, o_DMem_wData,   32'd0);
    endtask

    task automatic drive_ports();
        i_req0 = m_req[0]; i_we0 = m_we[0]; i_addr0 = m_addr[0]; i_wData0 = m_wd[0];
        i_req1 = m_req[1]; i_we1 = m_we[1]; i_addr1 = m_addr[1]; i_wData1 = m_wd[1];
    endtask

    task automatic clear_masters();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_req[m] = 1'b0; m_we[m] = 1'b0; m_addr[m] = '0; m_wd[m] = '0;
        end
    endtask

    task automatic model_reset();
        acc = '0;
        rsp = '0;
        last_id = 1'b1;  // M0 wins the first tie after reset
        q0.delete();
        q1.delete();
        clear_masters();
    endtask

    task automatic push(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wd = d;
        if (m == 0) q0.push_back(c);
        else        q1.push_back(c);
    endtask

    task automatic clear_hist();
        gnt_id_q.delete(); gnt_cyc_q.delete(); rv0_cyc_q.delete();
        rd0_q.delete(); rd1_q.delete(); err1_q.delete();
        we_seen = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       return 32'($urandom_range(0, 15) * 4);
        else if (sel == 7) return 32'hFC;
        else if (sel == 8) return 32'h100;
        else               return $urandom;
    endfunction

    task automatic new_cmd(input int m);
        cmd_t c;
        logic got;
        got = 1'b0;
        c   = '0;
        if (rnd_mode) begin
            if ($urandom_range(0, 1) == 1) begin
                c.we = 1'($urandom_range(0, 1)); c.addr = rand_addr(); c.wd = $urandom; got = 1'b1;
            end
        end else if (m == 0 && q0.size() > 0) begin
            c = q0.pop_front(); got = 1'b1;
        end else if (m == 1 && q1.size() > 0) begin
            c = q1.pop_front(); got = 1'b1;
        end
        if (got) begin
            m_req[m] = 1'b1; m_we[m] = c.we; m_addr[m] = c.addr; m_wd[m] = c.wd; m_st[m] = 1;
        end
    endtask

    // One clock cycle: drive requesters, check outputs, advance the model.
    task automatic step();
        txn_t nacc, nrsp;
        logic w, withdrew;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            withdrew = 1'b0;
            if (m_st[m] == 2) begin
                m_st[m] = 3;
            end else if (m_st[m] == 3) begin
                m_st[m] = 0; m_req[m] = 1'b0;
            end else if (m_st[m] == 1 && rnd_mode && $urandom_range(0, 9) == 0) begin
                m_st[m] = 0; m_req[m] = 1'b0; withdrew = 1'b1;
            end
            if (m_st[m] == 0 && !withdrew) new_cmd(m);
        end
        drive_ports();
        @(negedge clk);
        chk("gnt0",   32'(o_gnt0),    32'(acc.v && acc.id == 1'b0));
        chk("gnt1",   32'(o_gnt1),    32'(acc.v && acc.id == 1'b1));
        chk("mwe",    32'(o_DMem_we), 32'(acc.v && acc.we && !acc.err));
        chk("maddr",  o_DMem_addr,    acc.v ? acc.addr : 32'd0);
        chk("mwdata", o_DMem_wData,   acc.v ? acc.wd : 32'd0);
        chk("rv0",    32'(o_rvalid0), 32'(rsp.v && rsp.id == 1'b0));
        chk("rv1",    32'(o_rvalid1), 32'(rsp.v && rsp.id == 1'b1));
        chk("rdata",  o_rData,        rsp.v ? rsp.rd : 32'd0);
        chk("err",    32'(o_err),     32'(rsp.v && rsp.err));
        chk("busy",   32'(o_busy),    32'(acc.v || rsp.v));
        if (o_gnt0)    begin gnt_id_q.push_back(0); gnt_cyc_q.push_back(cyc); end
        if (o_gnt1)    begin gnt_id_q.push_back(1); gnt_cyc_q.push_back(cyc); end
        if (o_rvalid0) begin rd0_q.push_back(o_rData); rv0_cyc_q.push_back(cyc); end
        if (o_rvalid1) begin rd1_q.push_back(o_rData); err1_q.push_back(o_err); end
        if (o_DMem_we) we_seen = 1'b1;
        // advance: the accessed transaction becomes the response
        nrsp = acc;
        if (acc.v) begin
            nrsp.rd = (acc.we || acc.err) ? 32'd0 : ref_rd(acc.addr);
            if (acc.we && !acc.err) ref_wr(acc.addr, acc.wd);
        end
        // arbitration whenever nothing occupies the memory this cycle
        nacc = '0;
        if (!acc.v && (m_req[0] || m_req[1])) begin
            if (m_req[0] && m_req[1]) w = ~last_id;
            else                      w = m_req[1];
            nacc.v = 1'b1; nacc.id = w; nacc.we = m_we[w];
            nacc.addr = m_addr[w]; nacc.wd = m_wd[w]; nacc.err = exp_err(m_addr[w]);
            last_id = w;
            m_st[w] = 2;
        end
        acc = nacc;
        rsp = nrsp;
        cyc++;
    endtask

    function automatic logic is_idle();
        return !acc.v && !rsp.v && m_st[0] == 0 && m_st[1] == 0 &&
               !m_req[0] && !m_req[1] && q0.size() == 0 && q1.size() == 0;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (is_idle()) break;
        end
        if (!is_idle()) timeout_fail(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        clear_masters();
        drive_ports();
        #1;
        chk_zero(tag);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        model_reset();
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin : main
        int          start;
        logic [31:0] old20, pre40, d;
        for (int i = 0; i < 256; i++) begin
            d[7:0] = 8'($urandom_range(0, 255));
            mem[i]     <= d[7:0];
            ref_mem[i]  = d[7:0];
        end
        clear_masters();
        drive_ports();
        model_reset();
        clear_hist();
        do_reset("reset");

        // 1: write then read back
        clear_hist();
        start = cyc;
        push(0, 1'b1, 32'h10, 32'hDEADBEEF);
        push(0, 1'b0, 32'h10, 32'h0);
        run_until_idle("t1", 30);
        chk("t1_ngnt", 32'(gnt_cyc_q.size()), 32'd2);
        if (gnt_cyc_q.size() == 2) begin
            chk("t1_gnt_lat", 32'(gnt_cyc_q[0] - start), 32'd1);
            chk("t1_gnt2_lat", 32'(gnt_cyc_q[1] - start), 32'd3);
        end
        chk("t1_nrv", 32'(rd0_q.size()), 32'd2);
        if (rd0_q.size() == 2) begin
            chk("t1_rv_lat", 32'(rv0_cyc_q[0] - start), 32'd2);
            chk("t1_wr_rdata", rd0_q[0], 32'd0);
            chk("t1_rd_rdata", rd0_q[1], 32'hDEADBEEF);
        end

        // 2: simultaneous requests from reset, alternation
        do_reset("reset2");
        clear_hist();
        old20 = ref_rd(32'h20);
        push(0, 1'b0, 32'h20, 32'h0);
        push(1, 1'b1, 32'h20, 32'h11223344);
        push(0, 1'b0, 32'h20, 32'h0);
        push(1, 1'b1, 32'h24, 32'h55667788);
        run_until_idle("t2", 40);
        chk("t2_ngnt", 32'(gnt_id_q.size()), 32'd4);
        if (gnt_id_q.size() == 4) begin
            chk("t2_order0", 32'(gnt_id_q[0]), 32'd0);
            chk("t2_order1", 32'(gnt_id_q[1]), 32'd1);
            chk("t2_order2", 32'(gnt_id_q[2]), 32'd0);
        end
        if (rd0_q.size() == 2) begin
            chk("t2_old", rd0_q[0], old20);
            chk("t2_new", rd0_q[1], 32'h11223344);
        end else begin
            chk("t2_nrv0", 32'(rd0_q.size()), 32'd2);
        end

        // 3: misaligned and out-of-range accesses from M1
        clear_hist();
        push(1, 1'b0, 32'h13, 32'h0);
        push(1, 1'b0, 32'hFD, 32'h0);
        push(1, 1'b1, 32'h22, 32'hA5A5A5A5);
        push(1, 1'b0, 32'h100, 32'h0);
        run_until_idle("t3", 40);
        chk("t3_nrv1", 32'(rd1_q.size()), 32'd4);
        for (int i = 0; i < rd1_q.size(); i++) begin
            chk("t3_rdata", rd1_q[i], 32'd0);
            chk("t3_err", 32'(err1_q[i]), 32'd1);
        end
        chk("t3_we_never", 32'(we_seen), 32'd0);

        // 4: both requesters continuously busy for ten transactions
        clear_hist();
        for (int i = 0; i < 5; i++) begin
            push(0, 1'b1, 32'(32'h80 + i * 4), $urandom);
            push(1, 1'b0, 32'(32'h80 + i * 4), 32'h0);
        end
        run_until_idle("t4", 60);
        chk("t4_ngnt", 32'(gnt_id_q.size()), 32'd10);
        for (int i = 0; i < gnt_id_q.size(); i++) begin
            chk("t4_alt", 32'(gnt_id_q[i]), 32'(i % 2));
            if (i > 0) chk("t4_spacing", 32'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 32'd2);
        end

        // random traffic against the model
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) step();
        rnd_mode = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (m_st[m] == 1) begin m_st[m] = 0; m_req[m] = 1'b0; end
        end
        run_until_idle("rnd_drain", 20);

        // 5: reset asserted in the middle of a write ACCESS cycle
        clear_hist();
        pre40 = ref_rd(32'h40);
        push(0, 1'b1, 32'h40, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc.v) break;
        end
        if (!acc.v) begin
            timeout_fail("t5_grant");
        end else begin
            @(posedge clk);
            #2;
            chk("t5_gnt_before", 32'(o_gnt0), 32'd1);
            chk("t5_we_before", 32'(o_DMem_we), 32'd1);
            rstn = 1'b0;
            clear_masters();
            drive_ports();
            #1;
            chk_zero("t5_mid");
            @(posedge clk);
            #1;
            chk_zero("t5_hold");
            @(posedge clk);
            #2;
            rstn = 1'b1;
            model_reset();
        end
        clear_hist();
        push(0, 1'b0, 32'h40, 32'h0);
        run_until_idle("t5_read", 20);
        chk("t5_nrv", 32'(rd0_q.size()), 32'd1);
        if (rd0_q.size() == 1) chk("t5_prewrite", rd0_q[0], pre40);

        // 6: M0 request pulse that never reaches a clock edge
        clear_hist();
        @(posedge clk);
        #1;
        i_req0 = 1'b1; i_we0 = 1'b1; i_addr0 = 32'h8; i_wData0 = 32'h12345678;
        #2;
        i_req0 = 1'b0;
        @(negedge clk);
        chk("t6_busy_now", 32'(o_busy), 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("t6_no_gnt", 32'(gnt_id_q.size()), 32'd0);
        chk("t6_we_never", 32'(we_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
